// File: rtl/ahb_reg_bank.sv
// ahb_reg_bank: AHB-lite slave register bank, wait states, sub-word writes, hardware write port.
// Define AHB_REGBANK_ERR_EN to answer bad transfers with a two-cycle ERROR response.
module ahb_reg_bank #(
    parameter int N_REGS      = 16,
    parameter int WAIT_STATES = 0,
    parameter int HADDR_WIDTH = 32,
    parameter int HDATA_WIDTH = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   hsel_i,
    input  logic                   hreadyi_i,
    input  logic [HADDR_WIDTH-1:0] haddr_i,
    input  logic                   hwrite_i,
    input  logic [1:0]             htrans_i,
    input  logic [2:0]             hsize_i,
    input  logic [HDATA_WIDTH-1:0] hwdata_i,
    output logic                   hreadyo_o,
    output logic [1:0]             hresp_o,
    output logic [HDATA_WIDTH-1:0] hrdata_o,
    input  logic [N_REGS-1:0]      hw_we_i,
    input  logic [N_REGS*32-1:0]   hw_wdata_i,
    output logic [N_REGS*32-1:0]   regs_o,
    output logic [N_REGS-1:0]      wr_pulse_o
);

    localparam int IDX_W = $clog2(N_REGS);
    localparam logic [1:0] OKAY  = 2'b00;
    localparam logic [1:0] ERROR = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
`ifdef AHB_REGBANK_ERR_EN
        S_ERR1,
        S_ERR2,
`endif
        S_DATA
    } state_t;

    state_t           state;
    logic [2:0]       cnt;
    logic [IDX_W-1:0] idx_q;
    logic             write_q;
    logic [3:0]       be_q;
    logic             bad_q;
    logic [31:0]      regs     [N_REGS];
    logic [31:0]      reg_next [N_REGS];

    logic                   can_accept;
    logic                   accept;
    logic [HADDR_WIDTH-3:0] word_addr;
    logic [IDX_W-1:0]       new_idx;
    logic [3:0]             new_be;
    logic                   new_bad;
    logic                   bus_we;
    logic [IDX_W-1:0]       rd_idx;
    logic                   rd_bad;
    logic [31:0]            rd_val;
    logic                   unused_trans;

    assign unused_trans = htrans_i[0];

`ifdef AHB_REGBANK_ERR_EN
    assign can_accept = (state == S_IDLE) || (state == S_DATA)
                     || (state == S_ERR2);
`else
    assign can_accept = (state == S_IDLE) || (state == S_DATA);
`endif

    assign accept    = can_accept & hsel_i & hreadyi_i & htrans_i[1];
    assign word_addr = haddr_i[HADDR_WIDTH-1:2];
    assign new_idx   = haddr_i[IDX_W+1:2];

    always_comb begin
        new_be = 4'b1111;
        if (hsize_i == 3'd0)
            new_be = 4'b0001 << haddr_i[1:0];
        else if (hsize_i == 3'd1)
            new_be = haddr_i[1] ? 4'b1100 : 4'b0011;
    end

    assign new_bad = (word_addr >= (HADDR_WIDTH-2)'(N_REGS))
                  || (hsize_i > 3'd2)
                  || (hsize_i == 3'd1 && haddr_i[0])
                  || (hsize_i == 3'd2 && haddr_i[1:0] != 2'b00);

    assign bus_we = (state == S_DATA) && write_q && !bad_q;

    // hardware data is the base; bus-written bytes override it
    always_comb begin
        for (int k = 0; k < N_REGS; k++) begin
            reg_next[k] = hw_we_i[k] ? hw_wdata_i[32*k +: 32] : regs[k];
            if (bus_we && idx_q == IDX_W'(k)) begin
                for (int b = 0; b < 4; b++) begin
                    if (be_q[b])
                        reg_next[k][8*b +: 8] = hwdata_i[8*b +: 8];
                end
            end
        end
    end

    // read data is taken from the post-write view so back-to-back RAW sees new data
    assign rd_idx = (state == S_WAIT) ? idx_q : new_idx;
    assign rd_bad = (state == S_WAIT) ? bad_q : new_bad;
    assign rd_val = rd_bad ? 32'd0 : reg_next[rd_idx];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= S_IDLE;
            cnt        <= '0;
            idx_q      <= '0;
            write_q    <= 1'b0;
            be_q       <= '0;
            bad_q      <= 1'b0;
            hreadyo_o  <= 1'b1;
            hresp_o    <= OKAY;
            hrdata_o   <= '0;
            wr_pulse_o <= '0;
            for (int k = 0; k < N_REGS; k++)
                regs[k] <= '0;
        end else begin
            for (int k = 0; k < N_REGS; k++)
                regs[k] <= reg_next[k];
            wr_pulse_o <= '0;
            if (bus_we)
                wr_pulse_o[idx_q] <= 1'b1;

            unique case (state)
                S_WAIT: begin
                    if (cnt == 3'd0) begin
                        state     <= S_DATA;
                        hreadyo_o <= 1'b1;
                        if (!write_q)
                            hrdata_o <= rd_val;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
`ifdef AHB_REGBANK_ERR_EN
                S_ERR1: begin
                    state     <= S_ERR2;
                    hreadyo_o <= 1'b1;
                    hresp_o   <= ERROR;
                end
`endif
                default: begin
                    state     <= S_IDLE;
                    hreadyo_o <= 1'b1;
                    hresp_o   <= OKAY;
                    if (accept) begin
                        idx_q   <= new_idx;
                        write_q <= hwrite_i;
                        be_q    <= new_be;
                        bad_q   <= new_bad;
`ifdef AHB_REGBANK_ERR_EN
                        if (new_bad) begin
                            state     <= S_ERR1;
                            hreadyo_o <= 1'b0;
                            hresp_o   <= ERROR;
                        end else
`endif
                        if (WAIT_STATES > 0) begin
                            state     <= S_WAIT;
                            cnt       <= 3'(WAIT_STATES - 1);
                            hreadyo_o <= 1'b0;
                        end else begin
                            state <= S_DATA;
                            if (!hwrite_i)
                                hrdata_o <= rd_val;
                        end
                    end
                end
            endcase
        end
    end

    for (genvar k = 0; k < N_REGS; k++) begin : g_pack
        assign regs_o[32*k +: 32] = regs[k];
    end

endmodule

// File: tb/tb_ahb_reg_bank.sv
// tb_ahb_reg_bank: randomized bench for ahb_reg_bank against a word/byte array model.
// Instance a has no wait states; instance b has two.
module tb_ahb_reg_bank;

`ifdef AHB_REGBANK_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         hsel = 0, hwrite = 0;
    logic [31:0]  haddr = 0, hwdata = 0;
    logic [1:0]   htrans = 0;
    logic [2:0]   hsize = 0;
    logic         hreadyo;
    logic [1:0]   hresp;
    logic [31:0]  hrdata;
    logic [15:0]  hw_we = 0;
    logic [511:0] hw_wdata = 0;
    logic [511:0] regs;
    logic [15:0]  wr_pulse;

    logic         b_hsel = 0, b_hwrite = 0;
    logic [31:0]  b_haddr = 0, b_hwdata = 0;
    logic [1:0]   b_htrans = 0;
    logic [2:0]   b_hsize = 0;
    logic         b_hreadyo;
    logic [1:0]   b_hresp;
    logic [31:0]  b_hrdata;
    logic [15:0]  b_hw_we = 0;
    logic [511:0] b_hw_wdata = 0;
    logic [511:0] b_regs;
    logic [15:0]  b_wr_pulse;

    ahb_reg_bank #(.N_REGS(16), .WAIT_STATES(0)) dut_a (
        .clk_i(clk), .rst_i(rst), .hsel_i(hsel), .hreadyi_i(hreadyo),
        .haddr_i(haddr), .hwrite_i(hwrite), .htrans_i(htrans),
        .hsize_i(hsize), .hwdata_i(hwdata), .hreadyo_o(hreadyo),
        .hresp_o(hresp), .hrdata_o(hrdata), .hw_we_i(hw_we),
        .hw_wdata_i(hw_wdata), .regs_o(regs), .wr_pulse_o(wr_pulse)
    );

    ahb_reg_bank #(.N_REGS(16), .WAIT_STATES(2)) dut_b (
        .clk_i(clk), .rst_i(rst), .hsel_i(b_hsel), .hreadyi_i(b_hreadyo),
        .haddr_i(b_haddr), .hwrite_i(b_hwrite), .htrans_i(b_htrans),
        .hsize_i(b_hsize), .hwdata_i(b_hwdata), .hreadyo_o(b_hreadyo),
        .hresp_o(b_hresp), .hrdata_o(b_hrdata), .hw_we_i(b_hw_we),
        .hw_wdata_i(b_hw_wdata), .regs_o(b_regs), .wr_pulse_o(b_wr_pulse)
    );

    int checks = 0;
    int passes = 0;
    logic [31:0] model [16];

    function automatic logic [511:0] packm();
        logic [511:0] v;
        for (int k = 0; k < 16; k++) v[32*k +: 32] = model[k];
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one complete transfer on instance a; returns first and last response and wait count
    task automatic xfer(input logic wr, input logic [31:0] addr,
                        input logic [2:0] size, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic [1:0] resp1,
                        output logic [1:0] resp, output int waits,
                        output logic [15:0] pulse);
        hsel = 1; htrans = 2'b10; haddr = addr; hwrite = wr; hsize = size;
        tick();
        hsel = 0; htrans = 2'b00; hwdata = wdata;
        waits = 0;
        resp1 = hresp;
        while (hreadyo !== 1'b1 && waits < 20) begin
            waits++;
            tick();
        end
        rdata = hrdata;
        resp = hresp;
        tick();
        pulse = wr_pulse;
    endtask

    task automatic test_reset();
        rst = 1;
        tick(); tick();
        checks++; if (regs !== '0) $display("FAIL reset_regs got %h exp 0", regs); else passes++;
        checks++; if (hreadyo !== 1'b1) $display("FAIL reset_ready got %b exp 1", hreadyo); else passes++;
        checks++; if (hresp !== 2'b00) $display("FAIL reset_resp got %b exp 00", hresp); else passes++;
        checks++; if (hrdata !== '0) $display("FAIL reset_rdata got %h exp 0", hrdata); else passes++;
        checks++; if (wr_pulse !== '0) $display("FAIL reset_pulse got %h exp 0", wr_pulse); else passes++;
        rst = 0;
        tick(); tick();
        checks++; if (hreadyo !== 1'b1) $display("FAIL idle_ready got %b exp 1", hreadyo); else passes++;
        checks++; if (b_regs !== '0) $display("FAIL reset_b_regs got %h exp 0", b_regs); else passes++;
        for (int k = 0; k < 16; k++) model[k] = '0;
    endtask

    task automatic test_word();
        logic [31:0] rd; logic [1:0] r1, r; int w; logic [15:0] p;
        xfer(1, 32'h08, 3'd2, 32'hDEADBEEF, rd, r1, r, w, p);
        model[2] = 32'hDEADBEEF;
        checks++; if (w !== 0) $display("FAIL word_waits got %0d exp 0", w); else passes++;
        checks++; if (regs[95:64] !== 32'hDEADBEEF) $display("FAIL word_reg2 got %h exp deadbeef", regs[95:64]); else passes++;
        checks++; if (p !== 16'h0004) $display("FAIL word_pulse got %h exp 0004", p); else passes++;
        tick();
        checks++; if (wr_pulse !== 16'h0) $display("FAIL word_pulse_clear got %h exp 0", wr_pulse); else passes++;
        xfer(0, 32'h08, 3'd2, 32'h0, rd, r1, r, w, p);
        checks++; if (rd !== 32'hDEADBEEF) $display("FAIL word_read got %h exp deadbeef", rd); else passes++;
        checks++; if (w !== 0 || r !== 2'b00) $display("FAIL word_read_resp got w=%0d r=%b exp 0/00", w, r); else passes++;
    endtask

    task automatic test_lanes();
        logic [31:0] rd; logic [1:0] r1, r; int w; logic [15:0] p;
        xfer(1, 32'h04, 3'd2, 32'h11223344, rd, r1, r, w, p);
        xfer(1, 32'h05, 3'd0, 32'h5500AA66, rd, r1, r, w, p);
        checks++; if (regs[63:32] !== 32'h1122AA44) $display("FAIL byte_lane got %h exp 1122aa44", regs[63:32]); else passes++;
        xfer(1, 32'h06, 3'd1, 32'hBEEF7777, rd, r1, r, w, p);
        checks++; if (regs[63:32] !== 32'hBEEFAA44) $display("FAIL half_lane got %h exp beefaa44", regs[63:32]); else passes++;
        checks++; if (p !== 16'h0002) $display("FAIL half_pulse got %h exp 0002", p); else passes++;
        model[1] = 32'hBEEFAA44;
    endtask

    task automatic test_random();
        logic [31:0] rd, data, addr; logic [1:0] r1, r; int w; logic [15:0] p;
        int idx, size, nb, off; logic wr;
        for (int n = 0; n < 60; n++) begin
            idx = $urandom_range(0, 15);
            size = $urandom_range(0, 2);
            nb = 1 << size;
            off = $urandom_range(0, 4 / nb - 1) * nb;
            addr = idx * 4 + off;
            wr = 1'($urandom_range(0, 1));
            data = $urandom;
            xfer(wr, addr, 3'(size), data, rd, r1, r, w, p);
            if (wr) begin
                for (int b = off; b < off + nb; b++)
                    model[idx][8*b +: 8] = data[8*b +: 8];
                checks++;
                if (p !== 16'(1 << idx)) $display("FAIL rnd_pulse n=%0d got %h exp %h", n, p, 16'(1 << idx));
                else passes++;
            end else begin
                checks++;
                if (rd !== model[idx] || r !== 2'b00)
                    $display("FAIL rnd_read n=%0d got %h/%b exp %h/00", n, rd, r, model[idx]);
                else passes++;
            end
        end
        checks++; if (regs !== packm()) $display("FAIL rnd_regs got %h exp %h", regs, packm()); else passes++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] x;
        x = $urandom;
        hsel = 1; htrans = 2'b10; haddr = 32'h18; hwrite = 1; hsize = 3'd2;
        tick();
        hwdata = x; haddr = 32'h18; hwrite = 0;
        tick();
        hsel = 0; htrans = 2'b00;
        model[6] = x;
        checks++; if (hrdata !== x || hreadyo !== 1'b1) $display("FAIL b2b_raw got %h/%b exp %h/1", hrdata, hreadyo, x); else passes++;
        checks++; if (wr_pulse !== 16'h0040) $display("FAIL b2b_pulse got %h exp 0040", wr_pulse); else passes++;
        tick();
    endtask

    task automatic test_hw_port();
        hsel = 1; htrans = 2'b10; haddr = 32'h0C; hwrite = 1; hsize = 3'd0;
        tick();
        hsel = 0; htrans = 2'b00; hwdata = 32'h0;
        hw_we = 16'h0028;
        hw_wdata[32*3 +: 32] = 32'hFFFFFFFF;
        hw_wdata[32*5 +: 32] = 32'h13572468;
        tick();
        hw_we = '0;
        model[3] = 32'hFFFFFF00;
        model[5] = 32'h13572468;
        checks++; if (regs[127:96] !== 32'hFFFFFF00) $display("FAIL hw_bus_merge got %h exp ffffff00", regs[127:96]); else passes++;
        checks++; if (regs[191:160] !== 32'h13572468) $display("FAIL hw_only got %h exp 13572468", regs[191:160]); else passes++;
        checks++; if (wr_pulse !== 16'h0008) $display("FAIL hw_pulse got %h exp 0008", wr_pulse); else passes++;
        tick();
    endtask

    task automatic test_bad();
        logic [31:0] rd; logic [1:0] r1, r; int w; logic [15:0] p;
        logic [31:0] ba [4] = '{32'h40, 32'h0A, 32'h00, 32'h01};
        logic [2:0]  bs [4] = '{3'd2, 3'd2, 3'd3, 3'd1};
        xfer(1, 32'h00, 3'd2, 32'hCAFEF00D, rd, r1, r, w, p);
        model[0] = 32'hCAFEF00D;
        for (int i = 0; i < 4; i++) begin
            xfer(1, ba[i], bs[i], 32'hA5A5A5A5, rd, r1, r, w, p);
            checks++;
            if (w !== int'(ERR_EN) || r1 !== {1'b0, ERR_EN} || r !== {1'b0, ERR_EN})
                $display("FAIL bad_resp i=%0d got w=%0d r1=%b r=%b exp %0d/%b", i, w, r1, r, ERR_EN, ERR_EN);
            else passes++;
            checks++; if (p !== 16'h0) $display("FAIL bad_pulse i=%0d got %h exp 0", i, p); else passes++;
            checks++; if (regs !== packm()) $display("FAIL bad_regs i=%0d got %h exp %h", i, regs, packm()); else passes++;
        end
        xfer(0, 32'h00, 3'd2, 32'h0, rd, r1, r, w, p);
        xfer(0, 32'h40, 3'd2, 32'h0, rd, r1, r, w, p);
        checks++;
        if (rd !== (ERR_EN ? 32'hCAFEF00D : 32'h0) || r !== {1'b0, ERR_EN})
            $display("FAIL bad_read got %h/%b exp %h/%b", rd, r, ERR_EN ? 32'hCAFEF00D : 32'h0, ERR_EN);
        else passes++;
    endtask

    task automatic test_wait();
        int low;
        b_hw_we = 16'h0001;
        b_hw_wdata[31:0] = 32'h600DF00D;
        tick();
        b_hw_we = '0;
        b_hsel = 1; b_htrans = 2'b10; b_haddr = 32'h0; b_hwrite = 0; b_hsize = 3'd2;
        tick();
        b_hsel = 0; b_htrans = 2'b00;
        low = 0;
        while (b_hreadyo !== 1'b1 && low < 20) begin
            checks++; if (b_hresp !== 2'b00) $display("FAIL wait_resp got %b exp 00", b_hresp); else passes++;
            low++;
            tick();
        end
        checks++; if (low !== 2) $display("FAIL wait_cycles got %0d exp 2", low); else passes++;
        checks++; if (b_hrdata !== 32'h600DF00D) $display("FAIL wait_rdata got %h exp 600df00d", b_hrdata); else passes++;
        tick();
    endtask

    task automatic test_reset_mid();
        b_hw_we = 16'h0002;
        b_hw_wdata[63:32] = 32'h5555AAAA;
        tick();
        b_hw_we = '0;
        b_hsel = 1; b_htrans = 2'b10; b_haddr = 32'h04; b_hwrite = 1; b_hsize = 3'd2;
        tick();
        b_hsel = 0; b_htrans = 2'b00; b_hwdata = 32'h12345678;
        checks++; if (b_hreadyo !== 1'b0) $display("FAIL mid_in_wait got %b exp 0", b_hreadyo); else passes++;
        #2 rst = 1;
        #1;
        checks++; if (b_hreadyo !== 1'b1) $display("FAIL mid_ready got %b exp 1", b_hreadyo); else passes++;
        checks++; if (b_regs !== '0) $display("FAIL mid_regs got %h exp 0", b_regs); else passes++;
        tick();
        rst = 0;
        tick(); tick(); tick();
        checks++; if (b_regs[63:32] !== 32'h0) $display("FAIL mid_no_commit got %h exp 0", b_regs[63:32]); else passes++;
        checks++; if (b_wr_pulse !== '0 || b_hreadyo !== 1'b1) $display("FAIL mid_after got %h/%b exp 0/1", b_wr_pulse, b_hreadyo); else passes++;
    endtask

    initial begin
        test_reset();
        test_word();
        test_lanes();
        test_random();
        test_back_to_back();
        test_hw_port();
        test_bad();
        test_wait();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
